// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the single-precision add/normalise/round block
// Purpose: state enum, default field widths, exponent limits and the working-mantissa type.
// Ports: none (package).
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int EXP_MAX   = 255;
    localparam int BIAS      = 127;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        HOLD  = 3'd4
    } fpState_t;

    // {carry, hidden, fraction[22:0], guard, round, sticky}
    typedef logic [27:0] workMant_t;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter used by the single-cycle normaliser
// Purpose: counts zeros above the most significant set bit; returns W when din is zero.
// Built only when FPADD_FAST_NORM_EN is defined.
// Ports: din  input  [W-1:0]  value to scan
//        count output [CW-1:0] leading-zero count
`ifdef FPADD_FAST_NORM_EN
module fp_lzc
    import fp_pkg::*;
#(
    parameter int W  = $bits(workMant_t),
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule
`endif

// File: rtl/add_norm_round.sv
// rtl/add_norm_round.sv - aligned-mantissa add/subtract, normalise and round-nearest-even
// Purpose: takes pre-aligned operands sharing one exponent and produces an IEEE-754 result.
// Config:  FPADD_FAST_NORM_EN defined -> normalise in one cycle via fp_lzc;
//          undefined -> shift left one bit per cycle. Results are identical either way.
// Ports:   clk, rst_n (sync active-low); in_valid/in_ready operand handshake;
//          signA, signB, op, alignedMantissaA/B, exponentIn, guardBit, roundBit, stickyBit, shiftedB;
//          out_valid/out_ready result handshake; result, overflow, inexact.
module add_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   signA,
    input  logic                   signB,
    input  logic                   op,
    input  logic [MAN_W:0]         alignedMantissaA,
    input  logic [MAN_W:0]         alignedMantissaB,
    input  logic [EXP_W-1:0]       exponentIn,
    input  logic                   guardBit,
    input  logic                   roundBit,
    input  logic                   stickyBit,
    input  logic                   shiftedB,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   inexact
);

    localparam int WW = MAN_W + 5;
    localparam logic [EXP_W:0]   EXP_TOP = (EXP_W + 1)'((1 << EXP_W) - 1);
    localparam logic [EXP_W:0]   EXP_INC = (EXP_W + 1)'(1);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    fpState_t state, stateNext;

    logic             opSignA, opSignB, opOp, opShiftedB, opGuard, opRound, opSticky;
    logic [MAN_W:0]   opMantA, opMantB;
    logic [EXP_W-1:0] opExp;

    // Working magnitude without the carry bit: {hidden, fraction, G, R, S}.
    logic [WW-2:0]    work;
    logic [EXP_W-1:0] workExp;
    logic             workSign;

    // ---------------- ADD stage ----------------
    logic [WW-2:0]  extA, extB, diff;
    logic [WW-1:0]  sum, addWork;
    logic [EXP_W:0] addExpW;
    logic           effSub, bLarger, addSign, addZero, addOvf;

    always_comb begin
        extA    = opShiftedB ? {opMantA, 3'b000} : {opMantA, opGuard, opRound, opSticky};
        extB    = opShiftedB ? {opMantB, opGuard, opRound, opSticky} : {opMantB, 3'b000};
        effSub  = opSignA ^ opSignB ^ opOp;
        bLarger = extB > extA;
        sum     = {1'b0, extA} + {1'b0, extB};
        diff    = bLarger ? (extB - extA) : (extA - extB);
        addWork = sum;
        addExpW = {1'b0, opExp};
        addSign = opSignA;
        if (effSub) begin
            addWork = {1'b0, diff};
            addSign = bLarger ? (opSignB ^ opOp) : opSignA;
        end else if (sum[WW-1]) begin
            // Carry out: renormalise right, folding the dropped bit into sticky.
            addWork = {1'b0, sum[WW-1:2], sum[1] | sum[0]};
            addExpW = {1'b0, opExp} + EXP_INC;
        end
        addZero = (addWork == '0);
        addOvf  = (addExpW == EXP_TOP);
    end

    // ---------------- NORM stage ----------------
    logic [WW-2:0]    normWork;
    logic [EXP_W-1:0] normExp;
    logic             normFlush, normDone;

`ifdef FPADD_FAST_NORM_EN
    localparam int CW = $clog2(WW + 1);
    logic [CW-1:0] lzc, shamt;

    fp_lzc #(.W(WW), .CW(CW)) u_lzc (
        .din   ({1'b0, work}),
        .count (lzc)
    );

    // lzc includes the always-zero carry position, so the real shift is one less.
    // Flushing happens when the shift would drive the exponent below 1.
    always_comb begin
        shamt     = lzc - CW'(1);
        normFlush = ({{(EXP_W + 1 - CW){1'b0}}, lzc} > {1'b0, workExp});
        normWork  = work << shamt;
        normExp   = workExp - {{(EXP_W - CW){1'b0}}, shamt};
        normDone  = 1'b1;
    end
`else
    always_comb begin
        normDone  = work[WW-2];
        normFlush = !work[WW-2] && (workExp == EXP_ONE);
        normWork  = work[WW-2] ? work : {work[WW-3:0], 1'b0};
        normExp   = work[WW-2] ? workExp : (workExp - EXP_ONE);
    end
`endif

    // ---------------- ROUND stage ----------------
    logic [MAN_W:0]   fracSum;
    logic [EXP_W:0]   rndExpW;
    logic             rndInc, rndCarry, rndOvf, rndInexact;

    always_comb begin
        rndInc     = work[2] & (work[1] | work[0] | work[3]);
        rndInexact = work[2] | work[1] | work[0];
        // Hidden bit is set here, so a fraction carry means the mantissa reached 2^(MAN_W+1).
        fracSum    = {1'b0, work[WW-3:3]} + {{MAN_W{1'b0}}, rndInc};
        rndCarry   = fracSum[MAN_W];
        rndExpW    = {1'b0, workExp} + {{EXP_W{1'b0}}, rndCarry};
        rndOvf     = (rndExpW == EXP_TOP);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (in_valid) stateNext = ADD;
            ADD:     stateNext = (addZero || addOvf) ? HOLD : NORM;
            NORM:    if (normFlush) stateNext = HOLD;
                     else if (normDone) stateNext = ROUND;
            ROUND:   stateNext = HOLD;
            HOLD:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opSignA    <= signA;
                    opSignB    <= signB;
                    opOp       <= op;
                    opMantA    <= alignedMantissaA;
                    opMantB    <= alignedMantissaB;
                    opExp      <= exponentIn;
                    opGuard    <= guardBit;
                    opRound    <= roundBit;
                    opSticky   <= stickyBit;
                    opShiftedB <= shiftedB;
                    overflow   <= 1'b0;
                    inexact    <= 1'b0;
                end
                ADD: begin
                    work     <= addWork[WW-2:0];
                    workExp  <= addExpW[EXP_W-1:0];
                    workSign <= addSign;
                    if (addZero) begin
                        result <= '0;
                    end else if (addOvf) begin
                        result   <= {addSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        overflow <= 1'b1;
                        inexact  <= 1'b1;
                    end
                end
                NORM: begin
                    if (normFlush) begin
                        result  <= {workSign, {(EXP_W + MAN_W){1'b0}}};
                        inexact <= 1'b1;
                    end else begin
                        work    <= normWork;
                        workExp <= normExp;
                    end
                end
                ROUND: begin
                    if (rndOvf) begin
                        result <= {workSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else begin
                        result <= {workSign, rndExpW[EXP_W-1:0], fracSum[MAN_W-1:0]};
                    end
                    overflow <= rndOvf;
                    inexact  <= rndInexact;
                end
                default: ;
            endcase
        end
    end

endmodule
